// File: rtl/plot_arbiter.sv
// rtl/plot_arbiter.sv - round-robin arbiter multiplexing object pixel streams onto the VGA adapter port
// Optional pixel range clip enabled by defining PLOT_ARB_CLIP_EN.
module plot_arbiter #(
   parameter int N       = 3,
   parameter int XSCREEN = 160,
   parameter int YSCREEN = 120,
   parameter int TIMEOUT = 2**21
) (
   input  logic           CLOCK_50,
   input  logic           Resetn,
   input  logic [N*8-1:0] req_x,
   input  logic [N*7-1:0] req_y,
   input  logic [N*3-1:0] req_color,
   input  logic [N-1:0]   req_plot,
   input  logic [N-1:0]   req_row,
   output logic [N-1:0]   enable,
   output logic [1:0]     grant,
   output logic [7:0]     VGA_X,
   output logic [6:0]     VGA_Y,
   output logic [2:0]     VGA_COLOR,
   output logic           plot,
   output logic           timeout
);

   localparam int WDW = $clog2(TIMEOUT);
`ifdef PLOT_ARB_CLIP_EN
   localparam bit CLIP_EN = 1'b1;
`else
   localparam bit CLIP_EN = 1'b0;
`endif

   typedef enum logic {SERVE, HANDOFF} state_t;

   state_t         state, state_nxt;
   logic [WDW-1:0] wd, wd_nxt;
   logic [1:0]     grant_nxt;
   logic           timeout_nxt;
   logic [7:0]     cur_x;
   logic [6:0]     cur_y;
   logic [2:0]     cur_color;
   logic           cur_plot, cur_row;
   logic           in_range, pix_ok, load_pix, wd_hit;

   // Select the granted object's request lines; everything else is ignored.
   always_comb begin
      cur_x     = '0;
      cur_y     = '0;
      cur_color = '0;
      cur_plot  = 1'b0;
      cur_row   = 1'b0;
      enable    = '0;
      for (int k = 0; k < N; k++) begin
         if (grant == 2'(k)) begin
            cur_x     = req_x[k*8 +: 8];
            cur_y     = req_y[k*7 +: 7];
            cur_color = req_color[k*3 +: 3];
            cur_plot  = req_plot[k];
            cur_row   = req_row[k];
            enable[k] = (state == SERVE);
         end
      end
   end

   assign in_range = (cur_x < XSCREEN[7:0]) && (cur_y < YSCREEN[6:0]);
   assign pix_ok   = !CLIP_EN || in_range;
   assign load_pix = (state == SERVE) && cur_plot && pix_ok;
   assign wd_hit   = (wd == WDW'(TIMEOUT - 1));

   always_comb begin
      state_nxt   = state;
      grant_nxt   = grant;
      wd_nxt      = wd;
      timeout_nxt = 1'b0;
      case (state)
         SERVE: begin
            if (cur_row || wd_hit) begin
               state_nxt   = HANDOFF;
               wd_nxt      = '0;
               // A simultaneous row indication takes precedence over the watchdog.
               timeout_nxt = !cur_row;
            end else begin
               wd_nxt = wd + 1'b1;
            end
         end
         HANDOFF: begin
            state_nxt = SERVE;
            grant_nxt = (grant == 2'(N - 1)) ? 2'd0 : grant + 2'd1;
         end
         default: state_nxt = SERVE;
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge Resetn) begin
      if (!Resetn) begin
         state     <= SERVE;
         grant     <= 2'd0;
         wd        <= '0;
         timeout   <= 1'b0;
         VGA_X     <= 8'd0;
         VGA_Y     <= 7'd0;
         VGA_COLOR <= 3'd0;
         plot      <= 1'b0;
      end else begin
         state   <= state_nxt;
         grant   <= grant_nxt;
         wd      <= wd_nxt;
         timeout <= timeout_nxt;
         plot    <= load_pix;
         if (load_pix) begin
            VGA_X     <= cur_x;
            VGA_Y     <= cur_y;
            VGA_COLOR <= cur_color;
         end
      end
   end

endmodule
